// File: rtl/dbus_bridge.sv
// dbus_bridge
//   Bridges the memory-access stage's combinational data-memory request onto a
//   registered req/gnt + rvalid data bus and returns load data to the pipeline.
//   stall_req_o stays high until the transfer completes, so the pipeline
//   tolerates wait-state memory. A pipeline flush aborts the access in flight.
//   Only one transfer is ever outstanding on the bus.
//
// Ports
//   clk_i, rst_i         clock, synchronous active-high reset
//   mem_ce_i/we/sel/addr/wdata   request from the memory stage
//   flush_i              pipeline flush, aborts the current access
//   mem_rdata_o          load data, valid in the DONE cycle
//   mem_err_o            bus error or timeout, valid in the DONE cycle
//   stall_req_o          stall request to pipeline control
//   dbus_req_o/we/be/addr/wdata  bus request and fields
//   dbus_gnt_i           request accepted (qualified by dbus_req_o)
//   dbus_rvalid_i/rdata/err      bus response (loads and stores both respond)
//
// Configuration
//   DBUS_TIMEOUT_EN      when defined, REQ/RESP/DRAIN give up after
//                        TIMEOUT_CYCLES cycles; REQ/RESP finish with mem_err_o=1,
//                        DRAIN returns to IDLE silently. When undefined,
//                        transfers wait indefinitely.

module dbus_bridge #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_err_o,
  output logic              stall_req_o,
  output logic              dbus_req_o,
  input  logic              dbus_gnt_i,
  output logic              dbus_we_o,
  output logic [3:0]        dbus_be_o,
  output logic [ADDR_W-1:0] dbus_addr_o,
  output logic [DATA_W-1:0] dbus_wdata_o,
  input  logic              dbus_rvalid_i,
  input  logic [DATA_W-1:0] dbus_rdata_i,
  input  logic              dbus_err_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state;

  logic              hold_we;
  logic [3:0]        hold_sel;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_wdata;

  // High in the last cycle a waiting state is allowed to spend.
  logic tmo;

`ifdef DBUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt;
  logic             cnt_restart;

  // Restart whenever the current waiting state is about to be left for
  // another waiting state, so each of REQ/RESP/DRAIN starts counting at 0.
  assign cnt_restart = (state == S_IDLE) || (state == S_DONE) ||
                       ((state == S_REQ)  && (flush_i || dbus_gnt_i)) ||
                       ((state == S_RESP) && flush_i);

  always_ff @(posedge clk_i) begin
    if (rst_i || cnt_restart) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign tmo = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  // TIMEOUT_CYCLES has no effect without the timeout counter.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign tmo = 1'b0;
`endif

  // Bus fields come straight from the memory stage while IDLE so a zero-wait
  // bus can grant in the first cycle; afterwards the hold registers keep them
  // stable until the grant.
  always_comb begin
    dbus_req_o   = 1'b0;
    dbus_we_o    = hold_we;
    dbus_be_o    = hold_sel;
    dbus_addr_o  = hold_addr;
    dbus_wdata_o = hold_wdata;
    case (state)
      S_IDLE: begin
        dbus_req_o   = mem_ce_i & ~flush_i;
        dbus_we_o    = mem_we_i;
        dbus_be_o    = mem_sel_i;
        dbus_addr_o  = mem_addr_i;
        dbus_wdata_o = mem_wdata_i;
      end
      S_REQ:   dbus_req_o = 1'b1;
      default: dbus_req_o = 1'b0;
    endcase
  end

  // DONE is the single cycle the pipeline may advance; DRAIN still stalls a
  // waiting access because its request cannot go out until IDLE.
  assign stall_req_o = mem_ce_i & ~flush_i & (state != S_DONE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      hold_we     <= 1'b0;
      hold_sel    <= '0;
      hold_addr   <= '0;
      hold_wdata  <= '0;
      mem_rdata_o <= '0;
      mem_err_o   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mem_ce_i) begin
            hold_we    <= mem_we_i;
            hold_sel   <= mem_sel_i;
            hold_addr  <= mem_addr_i;
            hold_wdata <= mem_wdata_i;
          end
          if (mem_ce_i && !flush_i) begin
            state <= dbus_gnt_i ? S_RESP : S_REQ;
          end
        end

        S_REQ: begin
          // A grant coinciding with the flush still owes a response.
          if (flush_i) begin
            state <= dbus_gnt_i ? S_DRAIN : S_IDLE;
          end else if (dbus_gnt_i) begin
            state <= S_RESP;
          end else if (tmo) begin
            state       <= S_DONE;
            mem_rdata_o <= '0;
            mem_err_o   <= 1'b1;
          end
        end

        S_RESP: begin
          if (dbus_rvalid_i) begin
            if (flush_i) begin
              state <= S_IDLE;
            end else begin
              state       <= S_DONE;
              mem_rdata_o <= hold_we ? '0 : dbus_rdata_i;
              mem_err_o   <= dbus_err_i;
            end
          end else if (flush_i) begin
            state <= S_DRAIN;
          end else if (tmo) begin
            state       <= S_DONE;
            mem_rdata_o <= '0;
            mem_err_o   <= 1'b1;
          end
        end

        S_DRAIN: begin
          if (dbus_rvalid_i || tmo) begin
            state <= S_IDLE;
          end
        end

        S_DONE: begin
          state     <= S_IDLE;
          mem_err_o <= 1'b0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_bridge.sv
// Testbench for dbus_bridge: directed transfers against a scripted bus.
// Each transfer pushes its hand-computed completion (rdata, err) into a
// queue; a monitor pops and compares whenever the pipeline would advance
// (mem_ce_i high, no flush, stall_req_o low).

module tb_dbus_bridge;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              mem_ce_i;
  logic              mem_we_i;
  logic [3:0]        mem_sel_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [DATA_W-1:0] mem_wdata_i;
  logic              flush_i;
  logic [DATA_W-1:0] mem_rdata_o;
  logic              mem_err_o;
  logic              stall_req_o;
  logic              dbus_req_o;
  logic              dbus_gnt_i;
  logic              dbus_we_o;
  logic [3:0]        dbus_be_o;
  logic [ADDR_W-1:0] dbus_addr_o;
  logic [DATA_W-1:0] dbus_wdata_o;
  logic              dbus_rvalid_i;
  logic [DATA_W-1:0] dbus_rdata_i;
  logic              dbus_err_i;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W:0] exp_q[$];  // {err, rdata}

  dbus_bridge #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .mem_ce_i     (mem_ce_i),
    .mem_we_i     (mem_we_i),
    .mem_sel_i    (mem_sel_i),
    .mem_addr_i   (mem_addr_i),
    .mem_wdata_i  (mem_wdata_i),
    .flush_i      (flush_i),
    .mem_rdata_o  (mem_rdata_o),
    .mem_err_o    (mem_err_o),
    .stall_req_o  (stall_req_o),
    .dbus_req_o   (dbus_req_o),
    .dbus_gnt_i   (dbus_gnt_i),
    .dbus_we_o    (dbus_we_o),
    .dbus_be_o    (dbus_be_o),
    .dbus_addr_o  (dbus_addr_o),
    .dbus_wdata_o (dbus_wdata_o),
    .dbus_rvalid_i(dbus_rvalid_i),
    .dbus_rdata_i (dbus_rdata_i),
    .dbus_err_i   (dbus_err_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Advance to just after the next active edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Scoreboard monitor: a completed access is visible when the pipeline is
  // allowed to advance.
  always @(negedge clk_i) begin
    if (!rst_i && mem_ce_i && !flush_i && !stall_req_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got rdata=%0h err=%0b with nothing expected",
                 mem_rdata_o, mem_err_o);
      end else begin
        logic [DATA_W:0] e;
        e = exp_q.pop_front();
        check("sb_rdata", 128'(mem_rdata_o), 128'(e[DATA_W-1:0]));
        check("sb_err", 128'(mem_err_o), 128'(e[DATA_W]));
      end
    end
  end

  // One complete transfer from IDLE. Called just after an active edge; returns
  // just after the edge that leaves DONE, with mem_ce_i dropped.
  task automatic do_xfer(input string name, input logic we, input logic [ADDR_W-1:0] addr,
                         input logic [3:0] sel, input logic [DATA_W-1:0] wdata,
                         input int gnt_wait, input int rsp_wait,
                         input logic [DATA_W-1:0] bus_rdata, input logic bus_err,
                         input logic [DATA_W-1:0] exp_rdata, input logic exp_err,
                         input int exp_stalls);
    int stalls;
    stalls = 0;
    exp_q.push_back({exp_err, exp_rdata});
    mem_ce_i    = 1'b1;
    mem_we_i    = we;
    mem_sel_i   = sel;
    mem_addr_i  = addr;
    mem_wdata_i = wdata;
    for (int i = 0; i <= gnt_wait; i++) begin
      dbus_gnt_i = (i == gnt_wait);
      @(negedge clk_i);
      check({name, "_req"}, 128'(dbus_req_o), 128'(1));
      check({name, "_fields"}, {dbus_we_o, dbus_be_o, dbus_addr_o, dbus_wdata_o},
            {we, sel, addr, wdata});
      if (stall_req_o) stalls++;
      step();
    end
    dbus_gnt_i = 1'b0;
    for (int i = 0; i <= rsp_wait; i++) begin
      dbus_rvalid_i = (i == rsp_wait);
      dbus_rdata_i  = (i == rsp_wait) ? bus_rdata : 32'hFFFF_FFFF;
      dbus_err_i    = (i == rsp_wait) ? bus_err : 1'b0;
      @(negedge clk_i);
      check({name, "_req_resp"}, 128'(dbus_req_o), 128'(0));
      if (stall_req_o) stalls++;
      step();
    end
    dbus_rvalid_i = 1'b0;
    dbus_err_i    = 1'b0;
    @(negedge clk_i);
    check({name, "_done_stall"}, 128'(stall_req_o), 128'(0));
    check({name, "_stall_cycles"}, 128'(stalls), 128'(exp_stalls));
    step();
    mem_ce_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i         = 1'b1;
    mem_ce_i      = 1'b0;
    mem_we_i      = 1'b0;
    mem_sel_i     = 4'h0;
    mem_addr_i    = '0;
    mem_wdata_i   = '0;
    flush_i       = 1'b0;
    dbus_gnt_i    = 1'b0;
    dbus_rvalid_i = 1'b0;
    dbus_rdata_i  = '0;
    dbus_err_i    = 1'b0;
    step();
    step();
    rst_i = 1'b0;
    @(negedge clk_i);
    check("reset_outputs", {mem_rdata_o, mem_err_o, stall_req_o, dbus_req_o},
          {32'h0, 1'b0, 1'b0, 1'b0});
    step();

    // Zero-wait load.
    do_xfer("load0", 1'b0, 32'h100, 4'b1111, 32'h0, 0, 0,
            32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0, 2);

    // Store with 3 grant waits and 1 response wait; stores return 0.
    do_xfer("store", 1'b1, 32'h204, 4'b1100, 32'h1234_5678, 3, 1,
            32'h55AA_55AA, 1'b0, 32'h0, 1'b0, 6);

    // Bus error on a load, then mem_err_o must clear.
    do_xfer("buserr", 1'b0, 32'h600, 4'b1111, 32'h0, 0, 0,
            32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D, 1'b1, 2);
    @(negedge clk_i);
    check("buserr_clear", 128'(mem_err_o), 128'(0));

    // Stray response in IDLE is ignored.
    dbus_rvalid_i = 1'b1;
    dbus_rdata_i  = 32'h7777_7777;
    dbus_err_i    = 1'b1;
    step();
    dbus_rvalid_i = 1'b0;
    dbus_err_i    = 1'b0;
    @(negedge clk_i);
    check("idle_rvalid_ignored", {mem_rdata_o, mem_err_o}, {32'hCAFE_F00D, 1'b0});
    step();

    // Flush while waiting for the response, with a new access queued behind.
    mem_ce_i    = 1'b1;
    mem_we_i    = 1'b0;
    mem_sel_i   = 4'b1111;
    mem_addr_i  = 32'h300;
    dbus_gnt_i  = 1'b1;
    @(negedge clk_i);
    check("flresp_req", 128'(dbus_req_o), 128'(1));
    step();
    dbus_gnt_i = 1'b0;
    flush_i    = 1'b1;
    @(negedge clk_i);
    check("flresp_stall_drop", 128'(stall_req_o), 128'(0));
    step();
    flush_i    = 1'b0;
    mem_addr_i = 32'h304;
    @(negedge clk_i);
    check("drain_hold", {dbus_req_o, stall_req_o, mem_rdata_o}, {1'b0, 1'b1, 32'hCAFE_F00D});
    step();
    dbus_rvalid_i = 1'b1;
    dbus_rdata_i  = 32'hBAD0_BAD0;
    @(negedge clk_i);
    check("drain_rvalid_req", 128'(dbus_req_o), 128'(0));
    step();
    dbus_rvalid_i = 1'b0;
    mem_ce_i      = 1'b0;
    @(negedge clk_i);
    check("drain_discard", {dbus_req_o, mem_rdata_o}, {1'b0, 32'hCAFE_F00D});
    step();
    do_xfer("after_drain", 1'b0, 32'h304, 4'b1111, 32'h0, 0, 0,
            32'h1111_1111, 1'b0, 32'h1111_1111, 1'b0, 2);

    // Flush in REQ without grant withdraws the request.
    mem_ce_i   = 1'b1;
    mem_addr_i = 32'h400;
    dbus_gnt_i = 1'b0;
    @(negedge clk_i);
    check("flreq_req0", 128'(dbus_req_o), 128'(1));
    step();
    flush_i = 1'b1;
    @(negedge clk_i);
    check("flreq_req1", {dbus_req_o, stall_req_o}, {1'b1, 1'b0});
    step();
    flush_i  = 1'b0;
    mem_ce_i = 1'b0;
    @(negedge clk_i);
    check("flreq_withdrawn", {dbus_req_o, stall_req_o}, {1'b0, 1'b0});
    step();

    // Back-to-back zero-wait loads.
    do_xfer("b2b_0", 1'b0, 32'h0, 4'b1111, 32'h0, 0, 0,
            32'hA0A0_A0A0, 1'b0, 32'hA0A0_A0A0, 1'b0, 2);
    do_xfer("b2b_4", 1'b0, 32'h4, 4'b1111, 32'h0, 0, 0,
            32'hB1B1_B1B1, 1'b0, 32'hB1B1_B1B1, 1'b0, 2);

    // Reset in the middle of RESP.
    mem_ce_i   = 1'b1;
    mem_addr_i = 32'h700;
    dbus_gnt_i = 1'b1;
    step();
    dbus_gnt_i = 1'b0;
    rst_i      = 1'b1;
    step();
    rst_i       = 1'b0;
    mem_ce_i    = 1'b0;
    mem_sel_i   = 4'h0;
    mem_addr_i  = '0;
    mem_wdata_i = '0;
    @(negedge clk_i);
    check("midresp_reset",
          {mem_rdata_o, mem_err_o, stall_req_o, dbus_req_o, dbus_we_o, dbus_be_o,
           dbus_addr_o, dbus_wdata_o},
          {32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0});
    step();

`ifdef DBUS_TIMEOUT_EN
    // Grant never comes: IDLE + 4 REQ cycles, then DONE with an error.
    exp_q.push_back({1'b1, 32'h0});
    mem_ce_i   = 1'b1;
    mem_addr_i = 32'h500;
    mem_sel_i  = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check("tmo_req_wait", {dbus_req_o, stall_req_o}, {1'b1, 1'b1});
      step();
    end
    @(negedge clk_i);
    check("tmo_done", {dbus_req_o, stall_req_o}, {1'b0, 1'b0});
    step();
    mem_ce_i      = 1'b0;
    dbus_rvalid_i = 1'b1;
    dbus_rdata_i  = 32'h3333_3333;
    @(negedge clk_i);
    check("tmo_late_rvalid", {mem_err_o, dbus_req_o}, {1'b0, 1'b0});
    step();
    dbus_rvalid_i = 1'b0;
`endif

    step();
    check("sb_empty", 128'(exp_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
